// File: rtl/seqdet_pkg.sv
// seqdet shared definitions: default pattern and
// parameter legality helper.
package seqdet_pkg;

  localparam int unsigned DEFAULT_PAT_LEN = 4;
  localparam logic [3:0]  DEFAULT_PATTERN = 4'b1011;

  function automatic bit pat_len_ok(
    input int unsigned len
  );
    return (len >= 2) && (len <= 16);
  endfunction

endpackage

// File: rtl/seqdet.sv
// seqdet: serial sync-word spotter, one registered
// pulse per occurrence of PATTERN in the bit stream.
module seqdet
  import seqdet_pkg::*;
#(
  parameter int unsigned        PAT_LEN = DEFAULT_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN,
  parameter bit                 OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  if (!pat_len_ok(PAT_LEN)) begin : g_bad_len
    $error("seqdet: PAT_LEN must be in 2..16");
  end

  localparam int unsigned CW = $clog2(PAT_LEN + 1);
  localparam logic [CW-1:0] FULL = CW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [CW-1:0]      fill_q, fill_d, fill_inc;
  logic               out_q;
  logic               match;
  logic               hist_unused;

  // oldest bit falls off the top; the compare uses the shifted value
  assign hist_unused = hist_q[PAT_LEN-1];

  always_comb begin
    hist_d   = {hist_q[PAT_LEN-2:0], in};
    fill_inc = (fill_q == FULL) ? fill_q
                                : fill_q + 1'b1;
    match    = (fill_inc == FULL) && (hist_d == PATTERN);
    fill_d   = (match && !OVERLAP) ? '0 : fill_inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= match;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_seqdet.sv
// tb_seqdet: eight seqdet variants on one shared stream,
// checked against a bit-queue model through a scoreboard.
module tb_seqdet;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in = 1'b0;
  logic [7:0] outv;

  int total = 0;
  int bad = 0;
  int pc[8];

  bit         hq[8][$];
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  seqdet #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1))
    u0 (.clk(clk), .reset(reset), .in(in), .out(outv[0]));
  seqdet #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0))
    u1 (.clk(clk), .reset(reset), .in(in), .out(outv[1]));
  seqdet #(.PAT_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1))
    u2 (.clk(clk), .reset(reset), .in(in), .out(outv[2]));
  seqdet #(.PAT_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b0))
    u3 (.clk(clk), .reset(reset), .in(in), .out(outv[3]));
  seqdet #(.PAT_LEN(2), .PATTERN(2'b10), .OVERLAP(1'b1))
    u4 (.clk(clk), .reset(reset), .in(in), .out(outv[4]));
  seqdet #(.PAT_LEN(2), .PATTERN(2'b10), .OVERLAP(1'b0))
    u5 (.clk(clk), .reset(reset), .in(in), .out(outv[5]));
  seqdet #(.PAT_LEN(8), .PATTERN(8'b1101_0010), .OVERLAP(1'b1))
    u6 (.clk(clk), .reset(reset), .in(in), .out(outv[6]));
  seqdet #(.PAT_LEN(8), .PATTERN(8'b1101_0010), .OVERLAP(1'b0))
    u7 (.clk(clk), .reset(reset), .in(in), .out(outv[7]));

  function automatic int len_of(input int i);
    if (i < 4) return 4;
    if (i < 6) return 2;
    return 8;
  endfunction

  function automatic logic [15:0] pat_of(input int i);
    if (i < 2) return 16'h000B;
    if (i < 4) return 16'h0000;
    if (i < 6) return 16'h0002;
    return 16'h00D2;
  endfunction

  function automatic bit ovl_of(input int i);
    return (i % 2) == 0;
  endfunction

  // match against the bits received since reset or last flush
  function automatic bit hit(input int i);
    int          n = hq[i].size();
    int          l = len_of(i);
    logic [15:0] p = pat_of(i);
    if (n < l) return 1'b0;
    for (int k = 0; k < l; k++)
      if (hq[i][n-l+k] != p[l-1-k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: out=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag,
                         input int got,
                         input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: count=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      hq[i].delete();
      pc[i] = 0;
    end
    sb.delete();
  endtask

  task automatic step(input logic b);
    logic [7:0] e;
    logic [7:0] exp;
    @(negedge clk);
    in = b;
    for (int i = 0; i < 8; i++) begin
      hq[i].push_back(b);
      e[i] = hit(i);
      if (e[i] && !ovl_of(i)) hq[i].delete();
      if (hq[i].size() > 16) void'(hq[i].pop_front());
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", outv, 8'hxx);
    end else begin
      exp = sb.pop_front();
      chk("stream", outv, exp);
    end
    for (int i = 0; i < 8; i++)
      if (outv[i] === 1'b1) pc[i]++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_async", outv, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in = 1'($urandom);
      @(posedge clk);
      #1;
      chk("reset_hold", outv, 8'h00);
    end
    clear_model();
    #2 reset = 1'b1;
  endtask

  initial begin
    logic [10:0] basic;
    basic = 11'b101_1010_1011;

    // reset behaviour and basic detection
    do_reset();
    for (int k = 10; k >= 0; k--) step(basic[k]);
    chk_int("basic_pulses", pc[0], 2);
    for (int k = 0; k < 10; k++) step(1'b1);
    chk_int("basic_hold_ones", pc[0], 2);

    // overlapping vs non-overlapping on 1011011
    do_reset();
    step(1); step(0); step(1); step(1);
    step(0); step(1); step(1);
    chk_int("overlap_on", pc[0], 2);
    chk_int("overlap_off", pc[1], 1);

    // fill gate with an all-zero pattern
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b0);
    chk_int("fill_gate_early", pc[2], 0);
    for (int k = 0; k < 5; k++) step(1'b0);
    chk_int("zeros_overlap", pc[2], 5);
    chk_int("zeros_no_overlap", pc[3], 2);

    // mid-stream reset discards partial history
    do_reset();
    step(1); step(0); step(1);
    #2 reset = 1'b0;
    #3 reset = 1'b1;
    clear_model();
    step(1);
    chk_int("async_partial", pc[0], 0);

    // reset while out is high forces it low at once
    do_reset();
    step(1); step(0); step(1); step(1);
    chk_int("pulse_before_drop", pc[0], 1);
    #1 reset = 1'b0;
    #1 chk("async_drop", outv, 8'h00);
    #1 reset = 1'b1;
    clear_model();

    // random stream against the model
    for (int k = 0; k < 10000; k++) step(1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
